// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: branch redirects,
// load-use interlocks and debug halt/step, with saturating event counters.
module pipe_hazard_ctrl #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_usesRt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rt,
    input  logic             EX_MEM_Seletor,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             hazard,
    output logic             flush_IF_ID,
    output logic             bubble_ID_EX,
    output logic             flush_EX_MEM,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, HALTED, STEP} state_t;

    localparam logic [1:0] REM_INIT = 2'(LOAD_USE_STALLS - 1);

    state_t     state, state_nxt;
    logic [1:0] rem, rem_nxt;
    logic       ld_use;
    logic       stall_evt;
    logic       flush_evt;

    assign ld_use = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                    ((ID_EX_rt == IF_ID_rs) || (IF_ID_usesRt && (ID_EX_rt == IF_ID_rt)));

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nxt    = state;
        rem_nxt      = rem;
        hazard       = 1'b0;
        flush_IF_ID  = 1'b0;
        bubble_ID_EX = 1'b0;
        flush_EX_MEM = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;

        if (reset) begin
            state_nxt = RUN;
            rem_nxt   = 2'd0;
        end else if (EX_MEM_Seletor) begin
            // Redirect beats everything: PC must load the target, younger stages are squashed.
            flush_IF_ID  = 1'b1;
            bubble_ID_EX = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_evt    = 1'b1;
            rem_nxt      = 2'd0;
            state_nxt    = ((state == HALTED) || (state == STEP)) ? HALTED : RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_req) begin
                        state_nxt = HALTED;
                    end else if (ld_use) begin
                        hazard       = 1'b1;
                        bubble_ID_EX = 1'b1;
                        stall_evt    = 1'b1;
                        if (LOAD_USE_STALLS > 1) begin
                            state_nxt = LU_STALL;
                            rem_nxt   = REM_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    hazard       = 1'b1;
                    bubble_ID_EX = 1'b1;
                    stall_evt    = 1'b1;
                    rem_nxt      = rem - 2'd1;
                    if (rem <= 2'd1) begin
                        state_nxt = RUN;
                        rem_nxt   = 2'd0;
                    end
                end
                HALTED: begin
                    hazard       = 1'b1;
                    bubble_ID_EX = 1'b1;
                    if (step_req)
                        state_nxt = STEP;
                    else if (!halt_req)
                        state_nxt = RUN;
                end
                STEP: begin
                    // A stepped instruction still honours the load-use interlock.
                    if (ld_use) begin
                        hazard       = 1'b1;
                        bubble_ID_EX = 1'b1;
                        stall_evt    = 1'b1;
                    end else begin
                        state_nxt = HALTED;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state     <= RUN;
            rem       <= 2'd0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            halted <= (state_nxt == HALTED) || (state_nxt == STEP);
            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the fetch stage `hazard` input, which freezes PC and IF/ID.
- Drives bubble/flush controls for IF/ID, ID/EX and EX/MEM.
- Arbitrates between branch redirects, load-use interlocks and a debug halt/step interface, and keeps saturating event counters.

Parameters:
- LOAD_USE_STALLS, 1, stall cycles per load-use hazard; legal range 1..3.
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- IF_ID_rs  in  5  rs field of the instruction in ID.
- IF_ID_rt  in  5  rt field of the instruction in ID.
- IF_ID_usesRt  in  1  ID instruction reads rt as a source.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_rt  in  5  destination of the load in EX.
- EX_MEM_Seletor  in  1  branch/jump taken; fetch selects EX_MEM_NewPC this cycle.
- halt_req  in  1  level; debug requests the pipeline to freeze.
- step_req  in  1  pulse; release one instruction while halted.
- hazard  out  1  freezes PC and IF/ID (fetch stage input).
- flush_IF_ID  out  1  IF/ID captures a NOP on this edge.
- bubble_ID_EX  out  1  ID/EX captures a NOP on this edge.
- flush_EX_MEM  out  1  EX/MEM captures a NOP on this edge.
- halted  out  1  registered; pipeline is frozen by debug.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  branch redirects, saturating.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset state: state=RUN, rem=0, halted=0, both counters 0. All combinational outputs are forced 0 while reset=1.
- Load-use detect: ld_use = ID_EX_MemRead & (ID_EX_rt!=0) & ((ID_EX_rt==IF_ID_rs) | (IF_ID_usesRt & ID_EX_rt==IF_ID_rt)).
- Priority: reset > branch (EX_MEM_Seletor) > halt > ld_use.
- Outputs are combinational from state and inputs, so they act on the same edge. State, rem, halted and counters update on posedge clk.
- Branch cycle, any state: flush_IF_ID=1, bubble_ID_EX=1, flush_EX_MEM=1, hazard=0 so PC loads the target. flush_cnt+1. rem cleared. Next state: RUN from RUN/LU_STALL, HALTED from HALTED/STEP.
- RUN:
  - halt_req → next HALTED, halted=1 next cycle. No stall this cycle.
  - else ld_use → hazard=1, bubble_ID_EX=1, stall_cnt+1. If LOAD_USE_STALLS>1: next LU_STALL with rem=LOAD_USE_STALLS-1.
  - else all outputs 0.
- LU_STALL: hazard=1, bubble_ID_EX=1, stall_cnt+1, rem-1. When rem==1 → RUN. halt_req is deferred until the stall completes.
- HALTED: hazard=1, bubble_ID_EX=1 (drains EX onward), halted=1.
  - step_req → STEP.
  - else !halt_req → RUN, halted=0 next cycle.
  - step_req and !halt_req in the same cycle: step wins.
- STEP:
  - If ld_use: behave as a load-use stall (hazard=1, bubble=1, stall_cnt+1) and remain in STEP.
  - Else hazard=0 for exactly one cycle (one instruction advances), then → HALTED.
  - step_req while in STEP is ignored.
- halted=1 in HALTED and STEP; 0 otherwise.
- Counters saturate at all-ones and never wrap. stall_cnt counts only load-use stall cycles, not halt cycles.
- Reset asserted in any state returns to RUN next edge with counters cleared; a pending stall or step is discarded.
- ID_EX_rt==0 never stalls.

Test Plan:
- Load to $t1 in EX, ID reads rs=$t1, LOAD_USE_STALLS=1 → hazard=1 and bubble_ID_EX=1 for exactly 1 cycle; stall_cnt=1; PC holds one cycle.
- Same hazard with LOAD_USE_STALLS=3 → hazard high 3 consecutive cycles; stall_cnt=3; returns to RUN.
- EX_MEM_Seletor=1 in the second LU_STALL cycle → that cycle hazard=0 and all three flush outputs 1; flush_cnt=1; next cycle RUN with outputs 0.
- halt_req=1 → halted=1 next cycle and hazard held. step_req pulse → exactly one cycle hazard=0, then hazard=1. halt_req=0 → halted=0 one cycle later.
- Preload stall_cnt to 16'hFFFF via repeated hazards (or CNT_W=2 build: 4 stalls) → counter stays at max.
- reset asserted mid LU_STALL → next cycle all outputs 0, counters 0, no residual stall.
